// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 read scheduler.
// Frame layout is {hum_i, hum_d, tmp_i, tmp_d, checksum}, MSB first.
package dht11_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StWait,
        StCheck,
        StResp
    } state_e;

    localparam int unsigned FrameW  = 40;
    localparam int unsigned HumIOff = 32;
    localparam int unsigned HumDOff = 24;
    localparam int unsigned TmpIOff = 16;
    localparam int unsigned TmpDOff = 8;
    localparam int unsigned CsumOff = 0;

    localparam logic RspOk   = 1'b1;
    localparam logic RspFail = 1'b0;

    // 8-bit wrapping sum of the four data bytes must equal the checksum byte.
    function automatic logic checksum_ok(input logic [FrameW-1:0] f);
        logic [7:0] sum;
        sum = f[HumIOff +: 8] + f[HumDOff +: 8] + f[TmpIOff +: 8] + f[TmpDOff +: 8];
        return sum == f[CsumOff +: 8];
    endfunction

endpackage

// File: rtl/dht11_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after the pointer wins.
// The pointer moves to one past the served index when adv_i is pulsed.
module dht11_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic            adv_i,
    input  logic [IdxW-1:0] adv_idx_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (adv_idx_i == IdxW'(NREQ - 1)) ? '0 : adv_idx_i + IdxW'(1);
        end
    end

    always_comb begin
        int unsigned j;
        logic        found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_q) + i) % NREQ;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dht11_read_scheduler.sv
// Shares one DHT11 driver between NREQ requesters with power-on/gap pacing,
// checksum validation and retries. Define DHT11_CACHE_EN to serve requests
// from the last good reading while the inter-read gap is still running.
module dht11_read_scheduler
    import dht11_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned POWER_ON_CYC = 50_000_000,
    parameter int unsigned GAP_CYC      = 100_000_000,
    parameter int unsigned TIMEOUT_CYC  = 2_500_000,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] ack_o,
    output logic [15:0]     rsp_hum_o,
    output logic [15:0]     rsp_temp_o,
    output logic            rsp_ok_o,
    output logic            drv_start_o,
    input  logic            drv_busy_i,
    input  logic            drv_done_i,
    input  logic [39:0]     drv_data_i
);

    localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GapMax = (POWER_ON_CYC > GAP_CYC) ? POWER_ON_CYC : GAP_CYC;
    localparam int unsigned GapW   = $clog2(GapMax) + 1;
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [GapW-1:0] GapBoot  = GapW'(POWER_ON_CYC - 1);
    localparam logic [GapW-1:0] GapLoad  = GapW'(GAP_CYC - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      RetryMax = 3'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [2:0]          retry_q, retry_d;
    logic [IdxW-1:0]     g_q, g_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                pend_q, pend_d;
    logic [FrameW-1:0]   frame_q, frame_d;
    logic                frame_vld_q, frame_vld_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                drv_start_q, drv_start_d;
    logic [15:0]         hum_q, hum_d;
    logic [15:0]         temp_q, temp_d;
    logic                ok_q, ok_d;
`ifdef DHT11_CACHE_EN
    logic                cache_vld_q, cache_vld_d;
    logic [15:0]         cache_hum_q, cache_hum_d;
    logic [15:0]         cache_temp_q, cache_temp_d;
`endif

    logic                gap_ok;
    logic                start;
    logic                arb_en;
    logic                arb_adv;
    logic [NREQ-1:0]     arb_grant;
    logic [IdxW-1:0]     arb_idx;

    assign gap_ok = (gap_q == '0);

    dht11_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .en_i      (arb_en),
        .adv_i     (arb_adv),
        .adv_idx_i (g_q),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_ok ? gap_q : gap_q - GapW'(1);
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        g_d         = g_q;
        gnt_d       = gnt_q;
        pend_d      = pend_q;
        frame_d     = frame_q;
        frame_vld_d = frame_vld_q;
        ack_d       = '0;
        drv_start_d = 1'b0;
        hum_d       = hum_q;
        temp_d      = temp_q;
        ok_d        = ok_q;
`ifdef DHT11_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_hum_d  = cache_hum_q;
        cache_temp_d = cache_temp_q;
`endif
        start   = 1'b0;
        arb_en  = 1'b0;
        arb_adv = 1'b0;

        unique case (state_q)
            // BOOT evaluates the IDLE start condition in the cycle gap_ok rises so
            // the first drv_start lands exactly POWER_ON_CYC cycles after reset.
            StBoot, StIdle: begin
                if (state_q == StIdle || gap_ok) begin
                    state_d = StIdle;
                    if (pend_q) begin
                        start = gap_ok && !drv_busy_i;
                    end else if (|req_i) begin
                        arb_en = 1'b1;
                        if (gap_ok && !drv_busy_i) begin
                            start   = 1'b1;
                            g_d     = arb_idx;
                            gnt_d   = arb_grant;
                            retry_d = '0;
                        end
`ifdef DHT11_CACHE_EN
                        else if (cache_vld_q && !gap_ok) begin
                            g_d     = arb_idx;
                            gnt_d   = arb_grant;
                            ack_d   = arb_grant;
                            hum_d   = cache_hum_q;
                            temp_d  = cache_temp_q;
                            ok_d    = RspOk;
                            state_d = StResp;
                        end
`endif
                    end
                    if (start) begin
                        drv_start_d = 1'b1;
                        gap_d       = GapLoad;
                        tmo_d       = '0;
                        pend_d      = 1'b0;
                        state_d     = StWait;
                    end
                end
            end
            StWait: begin
                if (tmo_q != TmoLast) begin
                    tmo_d = tmo_q + TmoW'(1);
                end
                if (drv_done_i) begin
                    frame_d     = drv_data_i;
                    frame_vld_d = 1'b1;
                    state_d     = StCheck;
                end else if (tmo_q == TmoLast) begin
                    frame_vld_d = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (frame_vld_q && checksum_ok(frame_q)) begin
                    hum_d   = {frame_q[HumIOff +: 8], frame_q[HumDOff +: 8]};
                    temp_d  = {frame_q[TmpIOff +: 8], frame_q[TmpDOff +: 8]};
                    ok_d    = RspOk;
                    ack_d   = gnt_q;
                    state_d = StResp;
`ifdef DHT11_CACHE_EN
                    cache_vld_d  = 1'b1;
                    cache_hum_d  = {frame_q[HumIOff +: 8], frame_q[HumDOff +: 8]};
                    cache_temp_d = {frame_q[TmpIOff +: 8], frame_q[TmpDOff +: 8]};
`endif
                end else if (retry_q < RetryMax) begin
                    retry_d = retry_q + 3'd1;
                    pend_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    ok_d    = RspFail;
                    ack_d   = gnt_q;
                    state_d = StResp;
                end
            end
            StResp: begin
                arb_adv = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StBoot;
            gap_q       <= GapBoot;
            tmo_q       <= '0;
            retry_q     <= '0;
            g_q         <= '0;
            gnt_q       <= '0;
            pend_q      <= 1'b0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            ack_q       <= '0;
            drv_start_q <= 1'b0;
            hum_q       <= '0;
            temp_q      <= '0;
            ok_q        <= 1'b0;
`ifdef DHT11_CACHE_EN
            cache_vld_q  <= 1'b0;
            cache_hum_q  <= '0;
            cache_temp_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            g_q         <= g_d;
            gnt_q       <= gnt_d;
            pend_q      <= pend_d;
            frame_q     <= frame_d;
            frame_vld_q <= frame_vld_d;
            ack_q       <= ack_d;
            drv_start_q <= drv_start_d;
            hum_q       <= hum_d;
            temp_q      <= temp_d;
            ok_q        <= ok_d;
`ifdef DHT11_CACHE_EN
            cache_vld_q  <= cache_vld_d;
            cache_hum_q  <= cache_hum_d;
            cache_temp_q <= cache_temp_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign drv_start_o = drv_start_q;
    assign rsp_hum_o   = hum_q;
    assign rsp_temp_o  = temp_q;
    assign rsp_ok_o    = ok_q;

endmodule
